snake_dir_input: RTL

Input stage directly upstream of the `Snake` game FSM. It takes the four raw active-low push-buttons, synchronizes and debounces them, and turns each new press into a direction change. Valid changes are buffered in a small queue so rapid presses between game steps are not lost. The game FSM consumes one queued direction per move via a `step` pulse, and the block presents the committed direction in the same 3-bit encoding the game FSM uses.

---
 rtl/snake_dir_input_if.sv | 21 ++
 rtl/snake_dir_input.sv | 134 +++++++++++++
 2 files changed

// File: rtl/snake_dir_input_if.sv
// snake_dir_input_if: raw buttons and step pulse into snake_dir_input, committed direction and queue status out.
interface snake_dir_input_if #(
   parameter int DEPTH = 2
);
   logic                     up_button;
   logic                     down_button;
   logic                     left_button;
   logic                     right_button;
   logic                     step;
   logic [2:0]               dir;
   logic [$clog2(DEPTH):0]   queue_count;
   logic                     overflow;
   modport master (
      output up_button, down_button, left_button, right_button, step,
      input  dir, queue_count, overflow
   );
   modport slave (
      input  up_button, down_button, left_button, right_button, step,
      output dir, queue_count, overflow
   );
endinterface

// File: rtl/snake_dir_input.sv
// snake_dir_input: synchronizes/debounces the four active-low buttons, queues new directions and commits one per step.
// Define SNAKE_DIR_DEBOUNCE_EN to build the per-button debouncers; without it the synchronizer output is used directly.
module snake_dir_input #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int DEPTH           = 2
) (
   input logic              clk,
   input logic              reset,
   snake_dir_input_if.slave s_if
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;

   // bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right
   logic [3:0]    w_raw_n;
   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    w_level;
   logic [3:0]    w_stable;
   logic [3:0]    r_prev;
   logic [3:0]    w_press;
   logic [2:0]    w_new_dir;
   logic [2:0]    w_last;
   logic [2:0]    w_rev_last;
   logic [PW-1:0] w_tail_idx;
   logic          w_ok;
   logic          w_pop;
   logic          w_full;
   logic          w_push;
   logic          w_drop;
   logic [2:0]    r_mem [DEPTH];
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [PW:0]   r_count;
   logic [2:0]    r_dir;
   logic          r_ovf;

   assign w_raw_n = {s_if.right_button, s_if.left_button, s_if.down_button, s_if.up_button};

   // two-flop synchronizer; reset to released so no phantom press follows reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= w_raw_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_level = ~r_sync2;

`ifdef SNAKE_DIR_DEBOUNCE_EN
   logic [3:0]       r_stable;
   logic [CNT_W-1:0] r_cnt [4];

   // stable follows the level only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stable <= '0;
         for (int b = 0; b < 4; b++) r_cnt[b] <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (w_level[b] == r_stable[b]) begin
               r_cnt[b] <= '0;
            end else if (r_cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_stable[b] <= w_level[b];
               r_cnt[b]    <= '0;
            end else begin
               r_cnt[b] <= r_cnt[b] + CNT_W'(1);
            end
         end
      end
   end

   assign w_stable = r_stable;
`else
   logic [CNT_W-1:0] w_unused_cfg;
   assign w_unused_cfg = CNT_W'(DEBOUNCE_CYCLES);
   assign w_stable     = w_level;
`endif

   // previous stable level for rising-edge (press) detection
   always_ff @(posedge clk) begin
      if (reset) r_prev <= '0;
      else       r_prev <= w_stable;
   end

   assign w_press    = w_stable & ~r_prev;
   assign w_tail_idx = r_wr - PW'(1);
   assign w_pop      = s_if.step && (r_count != '0);
   assign w_full     = r_count == (PW+1)'(DEPTH);

   // priority pick of the press, filtering against the most recent pending direction
   always_comb begin
      w_new_dir  = w_press[0] ? DIR_UP : w_press[1] ? DIR_DOWN : w_press[2] ? DIR_LEFT : w_press[3] ? DIR_RIGHT : 3'd0;
      w_last     = (r_count != '0) ? r_mem[w_tail_idx] : r_dir;
      w_rev_last = (w_last == DIR_UP) ? DIR_DOWN : (w_last == DIR_DOWN) ? DIR_UP : (w_last == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
      w_ok       = (w_new_dir != 3'd0) && (w_new_dir != w_last) && (w_new_dir != w_rev_last);
      w_push     = w_ok && (!w_full || w_pop);
      w_drop     = w_ok && w_full && !w_pop;
   end

   // circular direction queue, committed direction and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_dir   <= DIR_RIGHT;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= w_new_dir;
            r_wr        <= r_wr + PW'(1);
         end
         if (w_pop) begin
            r_dir <= r_mem[r_rd];
            r_rd  <= r_rd + PW'(1);
         end
         if (w_push && !w_pop) r_count <= r_count + (PW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   assign s_if.dir         = r_dir;
   assign s_if.queue_count = r_count;
   assign s_if.overflow    = r_ovf;
endmodule
